// File: rtl/forward_scoreboard.sv
// Forward scoreboard: tracks the destination register and result latency of
// the instructions in stages E..W, picks the bypass source for each D-stage
// read port, and raises a load-use / HI-LO stall for the D instruction.
module forward_scoreboard #(
  parameter int DW      = 32,
  parameter int NRP     = 2,
  parameter int NSTG    = 3,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                d_valid,
  input  logic [4:0]          d_dst,
  input  logic [1:0]          d_tnew,
  input  logic [5*NRP-1:0]    d_rd_addr,
  input  logic [2*NRP-1:0]    d_tuse,
  input  logic [DW*NRP-1:0]   d_rd_val,
  input  logic                d_md,
  input  logic                md_start,
  input  logic                md_div,
  input  logic [DW*NSTG-1:0]  stg_data,
  input  logic                flush,
  output logic                stall,
  output logic [DW*NRP-1:0]   fwd_data,
  output logic [3*NRP-1:0]    fwd_sel,
  output logic                md_busy
);

  localparam int LAT_MAX = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int CW      = $clog2(LAT_MAX + 1);

  // Scoreboard entries, index s = pipeline stage s after D
  logic [NSTG-1:0]       ent_vld_q;
  logic [NSTG-1:0][4:0]  ent_dst_q;
  logic [NSTG-1:0][1:0]  ent_tnew_q;

  logic                  ld_vld_d;
  logic [1:0]            ld_tnew_d;
  logic [CW-1:0]         md_cnt_q, md_cnt_d;
  logic [NRP-1:0]        port_stall;
  logic [NSTG-1:0][DW-1:0] stg_w;

  assign stg_w = stg_data;

  // A stalled or flushed D instruction enters E as a bubble; $0 never tracked
  assign ld_vld_d  = d_valid & (d_dst != 5'd0) & ~stall & ~flush;
  assign ld_tnew_d = ld_vld_d ? d_tnew : 2'd0;

  // Scoreboard shifts every cycle; only entry 0 sees the stall bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_vld_q  <= '0;
      ent_dst_q  <= '0;
      ent_tnew_q <= '0;
    end else begin
      ent_vld_q[0]  <= ld_vld_d;
      ent_dst_q[0]  <= d_dst;
      ent_tnew_q[0] <= ld_tnew_d;
      for (int s = 1; s < NSTG; s++) begin
        ent_vld_q[s]  <= ent_vld_q[s-1];
        ent_dst_q[s]  <= ent_dst_q[s-1];
        ent_tnew_q[s] <= (ent_tnew_q[s-1] == 2'd0) ? 2'd0 : ent_tnew_q[s-1] - 2'd1;
      end
    end
  end

  // HI/LO busy counter: load only when idle, then count down to zero
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_cnt_q != '0)
      md_cnt_d = md_cnt_q - CW'(1);
    else if (md_start)
      md_cnt_d = md_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
  end

  // Counter register; reset abandons any in-flight mult/div
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) md_cnt_q <= '0;
    else        md_cnt_q <= md_cnt_d;
  end

  assign md_busy = (md_cnt_q != '0) | md_start;

  // Per-port bypass select; youngest producer wins
  for (genvar p = 0; p < NRP; p++) begin : g_port
    logic [4:0]    addr;
    logic [1:0]    tuse;
    logic          hit;
    logic [1:0]    hit_tnew;
    logic [2:0]    sel;
    logic [DW-1:0] data;

    assign addr = d_rd_addr[5*p +: 5];
    assign tuse = d_tuse[2*p +: 2];

    // Scan oldest to youngest so the lowest-index match overrides the rest
    always_comb begin
      hit      = 1'b0;
      hit_tnew = 2'd0;
      sel      = 3'd0;
      data     = d_rd_val[DW*p +: DW];
      for (int s = NSTG-1; s >= 0; s--) begin
        if (ent_vld_q[s] && (ent_dst_q[s] == addr) && (addr != 5'd0)) begin
          hit      = 1'b1;
          hit_tnew = ent_tnew_q[s];
          if (ent_tnew_q[s] == 2'd0) begin
            sel  = 3'(s + 1);
            data = stg_w[s];
          end else begin
            sel  = 3'd0;
            data = d_rd_val[DW*p +: DW];
          end
        end
      end
    end

    assign port_stall[p]         = hit & (hit_tnew > tuse);
    assign fwd_sel[3*p +: 3]     = sel;
    assign fwd_data[DW*p +: DW]  = data;
  end

  assign stall = d_valid & ((|port_stall) | (d_md & md_busy));

endmodule

// File: tb/tb_forward_scoreboard.sv
// Bench for forward_scoreboard: directed scenarios plus a randomized run
// checked against an instruction-history reference model.
module tb_forward_scoreboard;
  localparam int DW = 32, NRP = 2, NSTG = 3, MUL_LAT = 5, DIV_LAT = 10;

  logic clk = 1'b0, rst_n = 1'b0;
  logic d_valid, d_md, md_start, md_div, flush;
  logic [4:0] d_dst;
  logic [1:0] d_tnew;
  logic [5*NRP-1:0] d_rd_addr;
  logic [2*NRP-1:0] d_tuse;
  logic [DW*NRP-1:0] d_rd_val;
  logic [DW*NSTG-1:0] stg_data;
  logic stall, md_busy;
  logic [DW*NRP-1:0] fwd_data;
  logic [3*NRP-1:0] fwd_sel;

  int n_chk = 0, n_fail = 0;

  typedef struct packed { logic v; logic [4:0] dst; logic [1:0] tn0; } rec_t;
  rec_t hist [NSTG];

  forward_scoreboard #(.DW(DW), .NRP(NRP), .NSTG(NSTG), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_dst(d_dst), .d_tnew(d_tnew),
    .d_rd_addr(d_rd_addr), .d_tuse(d_tuse), .d_rd_val(d_rd_val), .d_md(d_md),
    .md_start(md_start), .md_div(md_div), .stg_data(stg_data), .flush(flush),
    .stall(stall), .fwd_data(fwd_data), .fwd_sel(fwd_sel), .md_busy(md_busy));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    d_valid = 0; d_dst = 0; d_tnew = 0; d_rd_addr = 0; d_tuse = 0;
    d_md = 0; md_start = 0; md_div = 0; flush = 0;
    for (int p = 0; p < NRP; p++) d_rd_val[DW*p +: DW] = $urandom;
    for (int s = 0; s < NSTG; s++) stg_data[DW*s +: DW] = $urandom;
  endtask

  // Short async reset pulse between clock edges, leaves a clean pipe
  task automatic fresh();
    idle(); tick();
    rst_n = 0; #2; rst_n = 1;
  endtask

  task automatic test_reset();
    idle();
    d_valid = 1; d_md = 1; d_rd_addr = {5'd4, 5'd3};
    tick(); tick(); #2;
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b want 0", stall); end
    n_chk++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL reset_md_busy: got %0b want 0", md_busy); end
    n_chk++; if (fwd_sel !== '0) begin n_fail++; $display("FAIL reset_fwd_sel: got %h want 0", fwd_sel); end
    n_chk++; if (fwd_data !== d_rd_val) begin n_fail++; $display("FAIL reset_fwd_data: got %h want %h", fwd_data, d_rd_val); end
    rst_n = 1;
    tick(); #2;
    n_chk++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_md_busy: got %0b want 0", md_busy); end
  endtask

  task automatic test_load_use();
    fresh(); tick();
    d_valid = 1; d_dst = 8; d_tnew = 2;
    tick();
    d_dst = 3; d_tnew = 0; d_rd_addr = {5'd8, 5'd8}; d_tuse = {2'd3, 2'd0};
    #2;
    n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL loaduse_stall1: got %0b want 1", stall); end
    n_chk++; if (fwd_sel[5:3] !== 3'd0) begin n_fail++; $display("FAIL loaduse_late_use_sel: got %0d want 0", fwd_sel[5:3]); end
    tick(); #2;
    n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL loaduse_stall2: got %0b want 1", stall); end
    tick(); #2;
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL loaduse_release: got %0b want 0", stall); end
    n_chk++; if (fwd_sel[2:0] !== 3'd3) begin n_fail++; $display("FAIL loaduse_sel: got %0d want 3", fwd_sel[2:0]); end
    n_chk++; if (fwd_data[DW-1:0] !== stg_data[2*DW +: DW]) begin n_fail++; $display("FAIL loaduse_data: got %h want %h", fwd_data[DW-1:0], stg_data[2*DW +: DW]); end
  endtask

  task automatic test_priority();
    fresh(); tick();
    d_valid = 1; d_dst = 5; d_tnew = 0;
    tick(); tick();
    d_dst = 0; d_rd_addr = {5'd5, 5'd5}; d_tuse = 0;
    #2;
    n_chk++; if (fwd_sel[2:0] !== 3'd1) begin n_fail++; $display("FAIL prio_sel: got %0d want 1", fwd_sel[2:0]); end
    n_chk++; if (fwd_data[DW-1:0] !== stg_data[DW-1:0]) begin n_fail++; $display("FAIL prio_data: got %h want %h", fwd_data[DW-1:0], stg_data[DW-1:0]); end
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL prio_stall: got %0b want 0", stall); end
    tick(); #2;
    n_chk++; if (fwd_sel[5:3] !== 3'd2) begin n_fail++; $display("FAIL prio_next_sel: got %0d want 2", fwd_sel[5:3]); end
    n_chk++; if (fwd_data[2*DW-1:DW] !== stg_data[2*DW-1:DW]) begin n_fail++; $display("FAIL prio_next_data: got %h want %h", fwd_data[2*DW-1:DW], stg_data[2*DW-1:DW]); end
  endtask

  task automatic test_zero();
    fresh(); tick();
    d_valid = 1; d_dst = 0; d_tnew = 3;
    tick();
    d_rd_addr = 0; d_tuse = 0;
    #2;
    n_chk++; if (fwd_sel !== '0) begin n_fail++; $display("FAIL zero_sel: got %h want 0", fwd_sel); end
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL zero_stall: got %0b want 0", stall); end
    n_chk++; if (fwd_data !== d_rd_val) begin n_fail++; $display("FAIL zero_data: got %h want %h", fwd_data, d_rd_val); end
  endtask

  task automatic test_mul();
    fresh(); tick();
    d_valid = 1; d_md = 1; d_dst = 0;
    #2;
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mul_pre_stall: got %0b want 0", stall); end
    tick();
    md_start = 1; md_div = 0;
    #2;
    n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL mul_stall_t0: got %0b want 1", stall); end
    for (int k = 1; k <= 5; k++) begin
      tick();
      md_start = (k == 2); md_div = 1;
      #2;
      n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL mul_stall_t%0d: got %0b want 1", k, stall); end
    end
    tick();
    md_start = 0;
    #2;
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mul_release: got %0b want 0", stall); end
    n_chk++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL mul_busy_end: got %0b want 0", md_busy); end
  endtask

  task automatic test_flush();
    fresh(); tick();
    d_valid = 1; d_dst = 9; d_tnew = 3; flush = 1;
    tick();
    flush = 0; d_dst = 0; d_tnew = 0; d_rd_addr = {5'd9, 5'd9}; d_tuse = 0;
    #2;
    n_chk++; if (fwd_sel !== '0) begin n_fail++; $display("FAIL flush_sel: got %h want 0", fwd_sel); end
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %0b want 0", stall); end
  endtask

  task automatic test_reset_mid_div();
    fresh(); tick();
    d_valid = 1; d_dst = 7; d_tnew = 3; md_start = 1; md_div = 1;
    tick(); md_start = 0;
    tick(); tick();
    d_dst = 0; d_rd_addr = {5'd7, 5'd7}; d_tuse = 0;
    #2;
    n_chk++; if (md_busy !== 1'b1) begin n_fail++; $display("FAIL middiv_busy_before: got %0b want 1", md_busy); end
    n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL middiv_stall_before: got %0b want 1", stall); end
    rst_n = 0; #1;
    n_chk++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL middiv_busy_async: got %0b want 0", md_busy); end
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL middiv_stall_async: got %0b want 0", stall); end
    n_chk++; if (fwd_sel !== '0) begin n_fail++; $display("FAIL middiv_sel_async: got %h want 0", fwd_sel); end
    rst_n = 1;
    tick(); #2;
    n_chk++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL middiv_busy_after: got %0b want 0", md_busy); end
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL middiv_stall_after: got %0b want 0", stall); end
  endtask

  // Model: each stage holds the instruction that left D s+1 cycles ago;
  // its remaining latency is its D-time tnew minus its age, floored at 0.
  task automatic test_random();
    int cyc, busy_until, hs, tn;
    logic exp_stall, exp_busy, haz;
    logic [2:0] exp_sel;
    logic [DW-1:0] exp_data;
    logic [4:0] a;
    fresh(); tick();
    for (int s = 0; s < NSTG; s++) hist[s] = '0;
    cyc = 0; busy_until = 0;
    for (int n = 0; n < 3000; n++) begin
      d_valid = ($urandom_range(0, 9) < 8);
      d_dst = 5'($urandom_range(0, 4));
      d_tnew = 2'($urandom_range(0, 3));
      for (int p = 0; p < NRP; p++) begin
        d_rd_addr[5*p +: 5] = 5'($urandom_range(0, 4));
        d_tuse[2*p +: 2] = 2'($urandom_range(0, 3));
        d_rd_val[DW*p +: DW] = $urandom;
      end
      for (int s = 0; s < NSTG; s++) stg_data[DW*s +: DW] = $urandom;
      d_md = ($urandom_range(0, 4) == 0);
      md_start = ($urandom_range(0, 7) == 0);
      md_div = 1'($urandom);
      flush = ($urandom_range(0, 9) == 0);
      #2;
      exp_busy = (cyc < busy_until) || md_start;
      haz = 0;
      for (int p = 0; p < NRP; p++) begin
        a = d_rd_addr[5*p +: 5];
        hs = -1;
        for (int s = 0; s < NSTG; s++)
          if (hs < 0 && hist[s].v && hist[s].dst == a && a != 0) hs = s;
        exp_sel = 0; exp_data = d_rd_val[DW*p +: DW];
        if (hs >= 0) begin
          tn = (int'(hist[hs].tn0) > hs) ? int'(hist[hs].tn0) - hs : 0;
          if (tn == 0) begin exp_sel = 3'(hs + 1); exp_data = stg_data[DW*hs +: DW]; end
          if (tn > int'(d_tuse[2*p +: 2])) haz = 1;
        end
        if (d_valid) begin
          n_chk++; if (fwd_sel[3*p +: 3] !== exp_sel) begin n_fail++; $display("FAIL rnd_sel cyc %0d port %0d: got %0d want %0d", cyc, p, fwd_sel[3*p +: 3], exp_sel); end
          n_chk++; if (fwd_data[DW*p +: DW] !== exp_data) begin n_fail++; $display("FAIL rnd_data cyc %0d port %0d: got %h want %h", cyc, p, fwd_data[DW*p +: DW], exp_data); end
        end
      end
      exp_stall = d_valid && (haz || (d_md && exp_busy));
      n_chk++; if (stall !== exp_stall) begin n_fail++; $display("FAIL rnd_stall cyc %0d: got %0b want %0b", cyc, stall, exp_stall); end
      n_chk++; if (md_busy !== exp_busy) begin n_fail++; $display("FAIL rnd_md_busy cyc %0d: got %0b want %0b", cyc, md_busy, exp_busy); end
      tick();
      for (int s = NSTG-1; s > 0; s--) hist[s] = hist[s-1];
      hist[0].v = d_valid && (d_dst != 0) && !exp_stall && !flush;
      hist[0].dst = d_dst;
      hist[0].tn0 = d_tnew;
      if (md_start && !(cyc < busy_until)) busy_until = cyc + 1 + (md_div ? DIV_LAT : MUL_LAT);
      cyc++;
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_priority();
    test_zero();
    test_mul();
    test_flush();
    test_reset_mid_div();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/forward_scoreboard.md
FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

Interface
REQ-001 SHALL have parameter DW, default 32, datapath width.
REQ-002 SHALL have parameter NRP, default 2, number of D-stage read ports.
REQ-003 SHALL have parameter NSTG, default 3, producer stages after D (0=E, NSTG-1=W); legal range 2..4.
REQ-004 SHALL have parameter MUL_LAT, default 5, HI/LO busy cycles for multiply.
REQ-005 SHALL have parameter DIV_LAT, default 10, HI/LO busy cycles for divide.
REQ-006 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-008 SHALL have port d_valid  in  1  D-stage instruction valid.
REQ-009 SHALL have port d_dst  in  5  D-stage destination register.
REQ-010 SHALL have port d_tnew  in  2  cycles after entering E until the result exists.
REQ-011 SHALL have port d_rd_addr  in  5*NRP  source register per port; port p at [5p+4:5p].
REQ-012 SHALL have port d_tuse  in  2*NRP  cycles until port p's operand is consumed.
REQ-013 SHALL have port d_rd_val  in  DW*NRP  register-file read data per port.
REQ-014 SHALL have port d_md  in  1  D instruction uses the HI/LO unit.
REQ-015 SHALL have port md_start  in  1  one-cycle E-stage mult/div start pulse.
REQ-016 SHALL have port md_div  in  1  qualifies md_start: 1=divide, 0=multiply.
REQ-017 SHALL have port stg_data  in  DW*NSTG  result presented by stage s at [DW*s+DW-1:DW*s].
REQ-018 SHALL have port flush  in  1  kill the D instruction instead of entering E.
REQ-019 SHALL have port stall  out  1  hold PC and D; combinational.
REQ-020 SHALL have port fwd_data  out  DW*NRP  selected operand per port.
REQ-021 SHALL have port fwd_sel  out  3*NRP  per port: 0=register file, s+1=stage s.
REQ-022 SHALL have port md_busy  out  1  HI/LO unit busy.

Function
REQ-023 SHALL hold NSTG scoreboard entries {valid, dst[4:0], tnew[1:0]}; entry s tracks stage s.
REQ-024 SHALL load entry 0 each cycle with {d_valid & (d_dst!=0), d_dst, d_tnew}, and with a bubble (valid=0) when stall or flush is 1.
REQ-025 SHALL move entry s-1 into entry s every cycle, tnew decremented and saturating at 0; entries never hold on stall.
REQ-026 SHALL match per port the lowest-index valid entry with dst==d_rd_addr and d_rd_addr!=0; older matches are ignored.
REQ-027 SHALL, with no match, output fwd_sel=0 and fwd_data=d_rd_val for that port.
REQ-028 SHALL, on a match with tnew==0, output fwd_sel=s+1 and fwd_data=stg_data[s], including s=NSTG-1 (W bypass).
REQ-029 SHALL assert stall when any port matches with tnew > d_tuse of that port; tnew>0 with tnew<=tuse gives fwd_sel=0, no stall.
REQ-030 SHALL keep an MD counter: on md_start while counter==0, load DIV_LAT if md_div else MUL_LAT, then decrement by 1 per cycle to 0.
REQ-031 SHALL ignore md_start while counter!=0 (no reload).
REQ-032 SHALL drive md_busy = (counter!=0) | md_start.
REQ-033 SHALL assert stall when d_valid & d_md & md_busy.
REQ-034 SHALL leave the MD counter unaffected by stall and flush.
REQ-035 SHALL ignore every read-port output while d_valid=0; stall from REQ-029 requires d_valid=1.

Reset
REQ-036 SHALL, while rst_n=0 and with no clock, clear all entries (valid=0, tnew=0) and the MD counter.
REQ-037 SHALL, during reset, give stall=0, md_busy=0 (md_start low), fwd_sel=0, fwd_data=d_rd_val.
REQ-038 SHALL abandon an in-progress mult/div on reset; the unit is idle at the first edge after release.

Verification
REQ-039 SHALL cover load-use (NSTG=3): D lw $8 with tnew=2, then D reading $8 with tuse=0 -> stall=1 for 2 cycles, then fwd_sel=3 and fwd_data=stg_data[2].
REQ-040 SHALL cover priority: $5 valid with tnew=0 in entries 0 and 1 -> fwd_sel=1, fwd_data=stg_data[0].
REQ-041 SHALL cover $0: entry dst=0 and d_rd_addr=0 -> fwd_sel=0, never stall.
REQ-042 SHALL cover multiply: md_start=1, md_div=0 at cycle t, D mfhi held -> stall cycles t..t+5, released at t+6; a second md_start at t+2 does not extend it.
REQ-043 SHALL cover flush: flush=1 with D writing $9 -> following reader of $9 sees fwd_sel=0, no stall.
REQ-044 SHALL cover reset mid-divide: rst_n low 3 cycles after md_start (div) -> md_busy=0 and all entries invalid immediately, no clock needed.
